// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and latency helper
// for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Accept-to-done latency of mul/div/mod.
   function automatic int calc_latency(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Magnitude-only shift/accumulate datapath:
// shift-add multiply or restoring divide, one step per enable.
module alu_iter_core #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               en,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic               last
);

   localparam int SW = $clog2(WIDTH);

   // hi half: partial product / remainder
   // lo half: shift register (multiplier / dividend -> quotient)
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   dvs;
   logic               mode_q;
   logic [SW-1:0]      step;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] part;
   logic [WIDTH:0] diff;

   assign last = step == SW'(WIDTH - 1);

   // One iteration of the selected algorithm.
   always_comb begin
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
      part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = part - {1'b0, dvs};
      if (mode_q) begin
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {sum, acc[WIDTH-1:1]};
      end
   end

   // Operand load and per-step register update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         dvs    <= '0;
         mode_q <= 1'b0;
         step   <= '0;
      end else if (load) begin
         acc    <= {{WIDTH{1'b0}}, a};
         dvs    <= b;
         mode_q <= div_mode;
         step   <= '0;
      end else if (en) begin
         acc    <= acc_nxt;
         step   <= step + SW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, iterative
// mul/div/mod with start/done handshake and flags.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] tmp1,
   input  logic [WIDTH-1:0] tmp2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero
);

   localparam int W = WIDTH;

   state_t state;
   state_t state_nxt;

   logic [2:0]     op_q;
   logic           neg_a;
   logic           neg_b;
   logic           sgn;
   logic           b_zero;
   logic           div_op;
   logic           long_op;
   logic           accept;
   logic           load;
   logic           last;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic [W-1:0]   add_r;
   logic [W-1:0]   sub_r;
   logic [W-1:0]   lo;
   logic [W-1:0]   hi;
   logic [2*W-1:0] acc_nxt;
   logic [2*W-1:0] prod;
   logic [W-1:0]   res_nxt;
   logic           ovf_nxt;
   logic           dz_nxt;
   logic           upd;

   assign b_zero  = tmp2 == '0;
   assign div_op  = (op == OP_DIV) || (op == OP_MOD);
   assign long_op = (op == OP_MUL) || (div_op && !b_zero);
   assign accept  = start && (state != CALC);
   assign a_mag   = tmp1[W-1] ? -tmp1 : tmp1;
   assign b_mag   = tmp2[W-1] ? -tmp2 : tmp2;
   assign add_r   = tmp1 + tmp2;
   assign sub_r   = tmp1 - tmp2;
   assign busy    = state == CALC;
   assign done    = state == FIX;
   assign sgn     = neg_a ^ neg_b;
   assign lo      = acc_nxt[W-1:0];
   assign hi      = acc_nxt[2*W-1:W];
   assign prod    = sgn ? -acc_nxt : acc_nxt;

   alu_iter_core #(.WIDTH(W)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .en       (busy),
      .div_mode (op != OP_MUL),
      .a        (a_mag),
      .b        (b_mag),
      .acc_nxt  (acc_nxt),
      .last     (last)
   );

   // Next state; the done cycle (FIX) also accepts a new start.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE, FIX: begin
            state_nxt = IDLE;
            if (start) begin
               load      = long_op;
               state_nxt = long_op ? CALC : FIX;
            end
         end
         CALC: if (last) state_nxt = FIX;
         default: state_nxt = IDLE;
      endcase
   end

   // Result and flags for short ops at accept, long ops on last step.
   always_comb begin
      res_nxt = '0;
      ovf_nxt = 1'b0;
      dz_nxt  = 1'b0;
      upd     = 1'b0;
      if (accept && !long_op) begin
         upd = 1'b1;
         case (op)
            OP_ADD: begin
               res_nxt = add_r;
               ovf_nxt = (tmp1[W-1] == tmp2[W-1])
                      && (add_r[W-1] != tmp1[W-1]);
            end
            OP_SUB: begin
               res_nxt = sub_r;
               ovf_nxt = (tmp1[W-1] != tmp2[W-1])
                      && (sub_r[W-1] != tmp1[W-1]);
            end
            OP_DIV, OP_MOD: dz_nxt = 1'b1;
            default: ;
         endcase
      end else if (busy && last) begin
         upd = 1'b1;
         case (op_q)
            OP_MUL: begin
               res_nxt = prod[W-1:0];
               ovf_nxt = prod != {{W{prod[W-1]}}, prod[W-1:0]};
            end
            OP_DIV: begin
               res_nxt = sgn ? -lo : lo;
               ovf_nxt = !sgn && lo[W-1];
            end
            default: res_nxt = neg_a ? -hi : hi;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latch op and operand signs for the long path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= OP_ADD;
         neg_a <= 1'b0;
         neg_b <= 1'b0;
      end else if (load) begin
         op_q  <= op;
         neg_a <= tmp1[W-1];
         neg_b <= tmp2[W-1];
      end
   end

   // Registered result and flags, held until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
      end else if (upd) begin
         result   <= res_nxt;
         zero     <= res_nxt == '0;
         overflow <= ovf_nxt;
         div_zero <= dz_nxt;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector and model-based bench for seq_alu
// at WIDTH=16.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] tmp1;
   logic [W-1:0] tmp2;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic         div_zero;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .tmp1     (tmp1),
      .tmp2     (tmp2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow),
      .div_zero (div_zero)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ovf;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one op and wait (bounded) for done.
   task automatic run(input logic [2:0] o,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      output logic [W-1:0] r,
                      output logic [2:0] f,
                      output int lat,
                      output bit busy_ok);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      tmp1  = a;
      tmp2  = b;
      @(negedge clk);
      start = 1'b0;
      tmp1  = W'($urandom);
      tmp2  = W'($urandom);
      op    = 3'($urandom);
      lat     = 1;
      busy_ok = 1'b1;
      while (!done && lat < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy) busy_ok = 1'b0;
      r = result;
      f = {zero, overflow, div_zero};
   endtask

   function automatic void model(input logic [2:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] r,
                                 output logic ovf,
                                 output logic dz,
                                 output int lat);
      longint la;
      longint lb;
      longint p;
      la  = longint'($signed(a));
      lb  = longint'($signed(b));
      r   = '0;
      ovf = 1'b0;
      dz  = 1'b0;
      lat = 1;
      p   = 0;
      case (o)
         OP_ADD, OP_SUB, OP_MUL: begin
            if (o == OP_ADD) p = la + lb;
            else if (o == OP_SUB) p = la - lb;
            else p = la * lb;
            r   = p[W-1:0];
            ovf = p != longint'($signed(r));
            if (o == OP_MUL) lat = calc_latency(W);
         end
         OP_DIV, OP_MOD: begin
            if (lb == 0) begin
               dz = 1'b1;
            end else begin
               lat = calc_latency(W);
               if (o == OP_DIV) begin
                  p   = la / lb;
                  r   = p[W-1:0];
                  ovf = p != longint'($signed(r));
               end else begin
                  p = la % lb;
                  r = p[W-1:0];
               end
            end
         end
         default: ;
      endcase
   endfunction

   initial begin
      logic [W-1:0] r;
      logic [2:0]   f;
      int           lat;
      bit           bok;
      int           seen;
      logic [W-1:0] er;
      logic         eo;
      logic         ed;
      int           el;
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1};
      vecs[1]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1};
      vecs[2]  = '{OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1};
      vecs[3]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1};
      vecs[4]  = '{OP_MUL, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0, 17};
      vecs[5]  = '{OP_MUL, 16'd300,  16'd300,  16'h5F90, 1'b1, 1'b0, 17};
      vecs[6]  = '{OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0, 17};
      vecs[7]  = '{OP_MOD, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 17};
      vecs[8]  = '{OP_MOD, 16'h0007, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 17};
      vecs[9]  = '{OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 17};
      vecs[10] = '{OP_DIV, 16'h0009, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
      vecs[11] = '{OP_MOD, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
      vecs[12] = '{3'b101, 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 1};
      vecs[13] = '{OP_MUL, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 17};
      vecs[14] = '{OP_MUL, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 17};
      vecs[15] = '{OP_DIV, 16'd100,  16'd7,    16'd14,   1'b0, 1'b0, 17};
      vecs[16] = '{OP_MOD, 16'd100,  16'd7,    16'd2,    1'b0, 1'b0, 17};

      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      tmp1  = '0;
      tmp2  = '0;
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst result", result, 0);
      check("rst flags", {zero, overflow, div_zero}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle done", done, 0);

      for (int i = 0; i < 17; i++) begin
         run(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, bok);
         check($sformatf("vec%0d result", i), r, vecs[i].res);
         check($sformatf("vec%0d flags", i), f,
               {vecs[i].res == '0, vecs[i].ovf, vecs[i].dz});
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d busy", i), bok, 1);
      end

      // Back-to-back adds, one per cycle.
      @(negedge clk);
      start = 1'b1;
      op    = OP_ADD;
      tmp1  = 16'd1;
      tmp2  = 16'd2;
      @(negedge clk);
      check("b2b done1", done, 1);
      check("b2b res1", result, 16'd3);
      tmp1 = 16'd10;
      tmp2 = 16'd20;
      @(negedge clk);
      check("b2b done2", done, 1);
      check("b2b res2", result, 16'd30);
      tmp1 = 16'd100;
      tmp2 = 16'd200;
      @(negedge clk);
      start = 1'b0;
      check("b2b done3", done, 1);
      check("b2b res3", result, 16'd300);
      @(negedge clk);
      check("b2b done off", done, 0);

      // Start while busy is ignored.
      start = 1'b1;
      op    = OP_MUL;
      tmp1  = 16'hFFFD;
      tmp2  = 16'h0007;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      op    = OP_ADD;
      tmp1  = 16'd1;
      tmp2  = 16'd1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("ign latency", lat, 17);
      check("ign result", result, 16'hFFEB);
      @(negedge clk);
      check("ign no 2nd done", done, 0);

      // Reset at mul step 5 aborts without done.
      start = 1'b1;
      op    = OP_MUL;
      tmp1  = 16'd300;
      tmp2  = 16'd300;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre-abort busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort result", result, 0);
      check("abort flags", {zero, overflow, div_zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort no done", seen, 0);
      run(OP_ADD, 16'd3, 16'd4, r, f, lat, bok);
      check("post-rst result", r, 16'd7);
      check("post-rst latency", lat, 1);

      // Random ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
         else rb = W'($urandom);
         if (i % 10 == 0) ra = 16'h8000;
         model(ro, ra, rb, er, eo, ed, el);
         run(ro, ra, rb, r, f, lat, bok);
         check($sformatf("rnd%0d op%0d %h,%h result", i, ro, ra, rb),
               r, er);
         check($sformatf("rnd%0d flags", i), f, {er == '0, eo, ed});
         check($sformatf("rnd%0d latency", i), lat, el);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the combinational HMMM ALU. Add and subtract complete in one cycle. Multiply, divide and modulo run iteratively over WIDTH cycles on a shared shift/accumulate datapath. A start/done handshake, registered results and a richer flag set (zero, overflow, divide-by-zero) let the core sequencer stall on long operations instead of closing timing on a combinational multiplier/divider.

## Interface
Parameters:
- WIDTH, 16: operand/result width in bits, signed two's complement, ≥4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, others illegal.
- tmp1  in  WIDTH  signed operand A; sampled with start.
- tmp2  in  WIDTH  signed operand B; sampled with start.
- busy  out  1  operation in flight; start ignored.
- done  out  1  one-cycle pulse; result/flags valid from this cycle.
- result  out  WIDTH  signed result; held until the next accepted start completes.
- zero  out  1  result == 0.
- overflow  out  1  signed result not representable in WIDTH.
- div_zero  out  1  div/mod with tmp2 == 0.

## Operation
- Reset values: busy=0, done=0, result=0, zero=0, overflow=0, div_zero=0; state IDLE.
- Operands and op are latched on acceptance. Later input changes have no effect.
- States:
  - IDLE: accept start. Add, sub and illegal ops finish directly and pulse done next cycle. Mul/div/mod go to CALC with |A|, |B| and the result sign latched. Div/mod with B=0 skips CALC: next cycle done=1, result=0, div_zero=1, overflow=0.
  - CALC: WIDTH iterations with a step counter counting 0..WIDTH-1. Mul uses shift-add on magnitudes into a 2·WIDTH accumulator. Div/mod use restoring division on magnitudes, producing quotient and remainder. After step WIDTH-1, go to FIX.
  - FIX: apply the sign, set flags, pulse done, go to IDLE.
- Add/sub: WIDTH-bit wrap. overflow is set when the operand signs match and the result sign differs (add), or when the operand signs differ and the result sign differs from A (sub).
- Mul: result is the low WIDTH bits of the signed product. overflow=1 if the full 2·WIDTH product ≠ sign-extension of result.
- Div: truncates toward zero. MIN/−1 gives result=MIN, overflow=1.
- Mod: sign follows the dividend. MIN%−1 gives 0, overflow=0.
- Illegal op: result=0, zero=1, other flags 0.
- zero is derived from the final registered result.
- Flags are updated only with done and held with result.

## Timing
- Latency L counts from the accept cycle T; done=1 in cycle T+L.
  - add/sub/illegal/divide-by-zero: L=1.
  - mul/div/mod: L=WIDTH+1, i.e. WIDTH CALC cycles plus 1 FIX cycle.
- busy=1 for cycles T+1 .. T+L−1. busy=0 in the done cycle.
- start is accepted in the done cycle, so back-to-back issue is supported: one add per cycle, or a mul every WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued and is not an error.
- rst_n asserted mid-operation aborts to IDLE immediately with all outputs at reset values. No done is produced for the aborted operation.
- done is never high for two consecutive cycles from a single start.

## Structure
- Package alu_pkg holds:
  - op-code localparams OP_ADD..OP_MOD;
  - the state encoding IDLE/CALC/FIX;
  - the mul/div latency constant as a function of WIDTH.
- One sub-module, alu_iter_core, owns the magnitude-only datapath: the 2·WIDTH accumulator/remainder, the shift register and the step counter, plus a mode input (mul/div). It performs one iteration per enabled cycle.
- seq_alu keeps the FSM, operand latching, sign handling, the single-cycle add/sub path and flag generation.

## Test plan
WIDTH=16 for all scenarios unless noted.
- Reset/idle: drive rst_n=0 mid-mul at step 5, then release → all outputs 0, no done pulse, next add 3+4 → result 7 at T+1.
- Add/sub flags: 0x7FFF+1 → 0x8000, overflow=1. 5−5 → 0, zero=1. Back-to-back adds on consecutive cycles → done every cycle.
- Mul: −3·7 → −21, done at T+17, busy high T+1..T+16. 300·300 → 0x5F90, overflow=1.
- Div/mod signs: −7/2 → −3. −7%2 → −1. 7%−2 → 1. 0x8000/−1 → 0x8000, overflow=1.
- Divide by zero: 9/0 → result 0, div_zero=1, done at T+1. A start pulsed during a busy mul is ignored, and the mul result is unchanged.
- Parameter sweep: WIDTH=8 and 32, random signed operands checked against a reference model. Latency is exactly WIDTH+1 for mul/div/mod.
